ic163_chain_ctrl: RTL and testbench

Controller that sequences a cascade of STAGES 4-bit 74x163-style synchronous counters used as a programmable divider/timer. It accepts a preset and mode over a valid/ready config port and drives the chain's clr_n/ld_n/enp/ent/data pins. It watches the last stage's rco and emits tick/done pulses. Supports one-shot and periodic operation with pause, resume and abort.

---
 rtl/ic163_chain_ctrl_pkg.sv | 18 +
 rtl/ic163_chain_ctrl.sv | 97 +++++++++
 tb/tb_ic163_chain_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ic163_chain_ctrl_pkg.sv
// Shared types and constants for the 74x163 counter-chain controller.
// Defines the FSM state encoding, the width of one counter slice and the mode encodings.
package ic163_pkg;

   localparam int STAGE_W = 4;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_IDLE  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

endpackage

// File: rtl/ic163_chain_ctrl.sv
// Sequencer for a cascade of 74x163 counters used as a divider/timer; drives the chain pins from state.
// tick/done are registered pulses one cycle after terminal count; config is accepted only in IDLE.
module ic163_chain_ctrl
   import ic163_pkg::*;
#(
   parameter int  STAGES = 2,
   localparam int W      = STAGE_W * STAGES
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_preset,
   input  logic         cfg_periodic,
   input  logic         start,
   input  logic         stop,
   output logic         busy,
   output logic         tick,
   output logic         done,
   output logic         cnt_clr_n,
   output logic         cnt_ld_n,
   output logic         cnt_enp,
   output logic         cnt_ent,
   output logic [W-1:0] cnt_d,
   input  logic         cnt_rco
);

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] preset_q;
   logic         periodic_q;
   logic         clr_q;
   logic         term_hit;
   logic         cfg_take;

   assign term_hit = (state == ST_RUN) && cnt_rco;
   assign cfg_take = cfg_valid && cfg_ready;

   assign cfg_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign cnt_clr_n = (state != ST_CLEAR);
   assign cnt_enp   = (state == ST_RUN);
   assign cnt_ent   = (state == ST_RUN);
   // The terminal edge reloads instead of wrapping, so the count never passes through zero.
   assign cnt_ld_n  = !((state == ST_LOAD) || term_hit);
   assign cnt_d     = preset_q;

   always_comb begin
      state_nxt = state;
      unique case (state)
         // clr_q stretches CLEAR by one cycle after a reset release; an abort gets a single CLEAR cycle.
         ST_CLEAR: if (!clr_q) state_nxt = ST_IDLE;
         ST_IDLE:  if (start && !stop) state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_RUN;
         ST_RUN: begin
            if (term_hit && (periodic_q == MODE_ONESHOT)) state_nxt = ST_IDLE;
            else if (stop)                                 state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (stop)       state_nxt = ST_CLEAR;
            else if (start) state_nxt = ST_RUN;
         end
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= ST_CLEAR;
         preset_q   <= '0;
         periodic_q <= MODE_ONESHOT;
         clr_q      <= 1'b1;
         tick       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= state_nxt;
         clr_q <= 1'b0;
         tick  <= term_hit;
         done  <= term_hit && (periodic_q != MODE_PERIODIC);
         // New config and a simultaneous start land on the same edge, so LOAD sees the new preset.
         if (cfg_take) begin
            preset_q   <= cfg_preset;
            periodic_q <= cfg_periodic;
         end
      end
   end

   a_tick_src: assert property (@(posedge clk) disable iff (clr)
      tick |-> $past((state == ST_RUN) && cnt_rco));

   a_done_with_tick: assert property (@(posedge clk) disable iff (clr)
      done |-> tick);

   a_hold_frozen: assert property (@(posedge clk) disable iff (clr)
      (state == ST_HOLD) |-> (cnt_ld_n && !cnt_enp && !cnt_ent && cnt_clr_n));

endmodule

// File: tb/tb_ic163_chain_ctrl.sv
// Directed bench for ic163_chain_ctrl closed around a behavioural two-stage 74x163 chain.
module tb_ic163_chain_ctrl;

   localparam int STAGES = 2;
   localparam int SW     = 4;
   localparam int W      = SW * STAGES;

   logic         clk;
   logic         clr;
   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_preset;
   logic         cfg_periodic;
   logic         start;
   logic         stop;
   logic         busy;
   logic         tick;
   logic         done;
   logic         cnt_clr_n;
   logic         cnt_ld_n;
   logic         cnt_enp;
   logic         cnt_ent;
   logic [W-1:0] cnt_d;
   logic         cnt_rco;
   logic [W-1:0] chain_q;

   int nvec = 0;
   int nerr = 0;

   ic163_chain_ctrl #(.STAGES(STAGES)) dut (
      .clk          (clk),
      .clr          (clr),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_preset   (cfg_preset),
      .cfg_periodic (cfg_periodic),
      .start        (start),
      .stop         (stop),
      .busy         (busy),
      .tick         (tick),
      .done         (done),
      .cnt_clr_n    (cnt_clr_n),
      .cnt_ld_n     (cnt_ld_n),
      .cnt_enp      (cnt_enp),
      .cnt_ent      (cnt_ent),
      .cnt_d        (cnt_d),
      .cnt_rco      (cnt_rco)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Chain model: each slice counts when enp, ent and every lower slice is at all-ones.
   assign cnt_rco = cnt_ent & (&chain_q);

   always @(posedge clk) begin
      logic en;
      for (int i = 0; i < STAGES; i++) begin
         en = cnt_enp & cnt_ent;
         for (int j = 0; j < SW * i; j++) en = en & chain_q[j];
         if (!cnt_clr_n)     chain_q[SW*i +: SW] <= '0;
         else if (!cnt_ld_n) chain_q[SW*i +: SW] <= cnt_d[SW*i +: SW];
         else if (en)        chain_q[SW*i +: SW] <= chain_q[SW*i +: SW] + 4'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Called at a negedge in IDLE; returns at the first RUN sample.
   task automatic go(input logic [W-1:0] p, input logic periodic);
      cfg_valid    = 1'b1;
      cfg_preset   = p;
      cfg_periodic = periodic;
      start        = 1'b1;
      step();
      cfg_valid = 1'b0;
      start     = 1'b0;
      check("load_ld_n", cnt_ld_n, 0);
      check("load_busy", busy, 1);
      step();
   endtask

   task automatic back_to_idle();
      int n;
      n    = 0;
      stop = 1'b1;
      while (busy && n < 10) begin
         step();
         n++;
      end
      stop = 1'b0;
      check("idle_reached", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nclr;
      int idx;
      clr = 1'b1; cfg_valid = 1'b0; cfg_preset = '0; cfg_periodic = 1'b0;
      start = 1'b0; stop = 1'b0;

      // reset: clr for 3 cycles, CLEAR persists one more
      nclr = 0;
      for (int i = 0; i < 3; i++) begin step(); if (!cnt_clr_n) nclr++; end
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); if (!cnt_clr_n) nclr++; end
      check("rst_clr_cycles", nclr, 4);
      check("rst_busy", busy, 0);
      check("rst_ready", cfg_ready, 1);
      check("rst_tick", tick, 0);
      check("rst_done", done, 0);
      check("rst_q", chain_q, 0);

      // periodic P=F6: tick every 10 cycles, sequence F6..FF
      go(8'hF6, 1'b1);
      for (int k = 0; k < 50; k++) begin
         check("per_q", chain_q, 8'hF6 + 8'(k % 10));
         check("per_tick", tick, (k != 0 && k % 10 == 0) ? 1 : 0);
         if (k == 6) begin
            check("run_ready", cfg_ready, 0);
            check("run_preset_kept", cnt_d, 8'hF6);
         end
         cfg_valid  = (k == 5);
         cfg_preset = 8'h12;
         step();
      end
      cfg_valid = 1'b0;
      back_to_idle();

      // one-shot P=FD: tick+done 3 cycles after RUN entry, chain holds P
      go(8'hFD, 1'b0);
      for (int k = 0; k < 3; k++) begin
         check("os_tick_early", tick, 0);
         check("os_busy", busy, 1);
         step();
      end
      check("os_tick", tick, 1);
      check("os_done", done, 1);
      check("os_idle", busy, 0);
      check("os_q", chain_q, 8'hFD);
      check("os_enp", cnt_enp, 0);
      step();
      check("os_tick_end", tick, 0);
      check("os_done_end", done, 0);

      // periodic P=00 with a 20-cycle pause at 0x40
      go(8'h00, 1'b1);
      for (int k = 0; k < 65; k++) begin
         if (k == 0 || k == 64) check("p0_q", chain_q, k);
         stop = (k == 64);
         step();
      end
      for (int h = 0; h < 20; h++) begin
         check("hold_q", chain_q, 8'h41);
         check("hold_enp", cnt_enp, 0);
         stop  = 1'b0;
         start = (h == 19);
         step();
      end
      start = 1'b0;
      check("resume_q", chain_q, 8'h41);
      idx = 85;
      while (!tick && idx < 400) begin
         step();
         idx++;
      end
      check("p0_first_tick", idx, 276);

      // pause then abort from HOLD, then start&stop in IDLE
      stop = 1'b1;
      step();
      check("pause_q", chain_q, 8'h01);
      check("pause_enp", cnt_enp, 0);
      check("pause_busy", busy, 1);
      step();
      check("abort_clr_n", cnt_clr_n, 0);
      stop = 1'b0;
      step();
      check("abort_idle", busy, 0);
      check("abort_q", chain_q, 0);
      start = 1'b1;
      stop  = 1'b1;
      step();
      check("ss_busy", busy, 0);
      check("ss_ld_n", cnt_ld_n, 1);
      start = 1'b0;
      stop  = 1'b0;

      // periodic P=FF: tick every cycle, stop on rco, clr mid-RUN
      go(8'hFF, 1'b1);
      check("ff_tick0", tick, 0);
      check("ff_ld_n", cnt_ld_n, 0);
      for (int k = 1; k < 5; k++) begin
         step();
         check("ff_tick", tick, 1);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("rs_tick", tick, 1);
      check("rs_hold_enp", cnt_enp, 0);
      check("rs_busy", busy, 1);
      check("rs_q", chain_q, 8'hFF);
      step();
      check("hold_no_tick", tick, 0);
      check("hold_q_ff", chain_q, 8'hFF);
      start = 1'b1;
      step();
      start = 1'b0;
      check("ff_resume_tick", tick, 0);
      step();
      check("ff_resume_tick2", tick, 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("mclr_clr_n", cnt_clr_n, 0);
      check("mclr_tick", tick, 0);
      check("mclr_done", done, 0);
      check("mclr_busy", busy, 1);
      step();
      check("mclr_tail", cnt_clr_n, 0);
      check("mclr_q", chain_q, 0);
      step();
      check("mclr_idle", busy, 0);
      check("mclr_preset", cnt_d, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
